gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_step.sv | 25 ++
 rtl/gray_counter.sv | 49 ++++
 tb/tb_gray_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared defaults and binary/Gray conversion helpers for the Gray counter.
package gray_pkg;

    localparam int DEF_WIDTH = 4;
    localparam bit DEF_WRAP  = 1'b1;

    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_step.sv
// gray_step: next binary count and boundary flag for one enabled counting step.
module gray_step
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit WRAP  = DEF_WRAP
) (
    input  logic [WIDTH-1:0] bin,
    input  logic             up,
    input  logic             en,
    output logic [WIDTH-1:0] bin_next,
    output logic             bound
);

    logic at_edge;

    always_comb begin
        at_edge  = up ? &bin : ~|bin;
        bound    = en && at_edge;
        // A saturating counter parks at the boundary instead of wrapping.
        bin_next = !en || (at_edge && !WRAP) ? bin :
                   up ? bin + WIDTH'(1) : bin - WIDTH'(1);
    end

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with registered Gray, binary and terminal-count outputs.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit WRAP  = DEF_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc
);

    logic [WIDTH-1:0] step_next, bin_d;
    logic             bound, tc_d;

    gray_step #(.WIDTH(WIDTH), .WRAP(WRAP)) u_step (
        .bin     (bin),
        .up      (up),
        .en      (en),
        .bin_next(step_next),
        .bound   (bound)
    );

    always_comb begin
        bin_d = clr ? '0 : load ? load_val : step_next;
        tc_d  = !clr && !load && bound;
    end

    // Gray is encoded from the next binary value so both outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            tc   <= 1'b0;
        end else begin
            bin  <= bin_d;
            gray <= WIDTH'(bin2gray(16'(bin_d)));
            tc   <= tc_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: three counter variants against an arithmetic model plus directed literal checks.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr, load, en, up;
    logic [3:0] load_val;
    logic [2:0] bin_a, gray_a, bin_b, gray_b;
    logic [3:0] bin_c, gray_c;
    logic       tc_a, tc_b, tc_c;
    logic [15:0] db[3], dg[3];
    logic        dt[3];
    int  n_chk = 0, n_fail = 0;
    int  mb[3];
    bit  mt[3], mv[3];
    logic [15:0] pg[3];
    int  wd[3] = '{3, 3, 4};
    bit  wr[3] = '{1'b1, 1'b0, 1'b1};
    int  exp_g[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(3), .WRAP(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[2:0]),
        .en(en), .up(up), .gray(gray_a), .bin(bin_a), .tc(tc_a));
    gray_counter #(.WIDTH(3), .WRAP(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[2:0]),
        .en(en), .up(up), .gray(gray_b), .bin(bin_b), .tc(tc_b));
    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .gray(gray_c), .bin(bin_c), .tc(tc_c));

    assign db[0] = 16'(bin_a);
    assign db[1] = 16'(bin_b);
    assign db[2] = 16'(bin_c);
    assign dg[0] = 16'(gray_a);
    assign dg[1] = 16'(gray_b);
    assign dg[2] = 16'(gray_c);
    assign dt[0] = tc_a;
    assign dt[1] = tc_b;
    assign dt[2] = tc_c;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: plain integer count, boundary = a step that would leave 0..2^W-1.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            int mx, nb;
            mx = (1 << wd[i]) - 1;
            if (!rst_n) begin
                mb[i] = 0; mt[i] = 0; mv[i] = 0;
            end else if (clr) begin
                mb[i] = 0; mt[i] = 0; mv[i] = 0;
            end else if (load) begin
                mb[i] = int'(load_val) & mx; mt[i] = 0; mv[i] = 0;
            end else if (en) begin
                nb = up ? mb[i] + 1 : mb[i] - 1;
                mt[i] = (nb > mx) || (nb < 0);
                if (mt[i]) nb = wr[i] ? (nb & mx) : mb[i];
                mv[i] = (nb != mb[i]);
                mb[i] = nb;
            end else begin
                mt[i] = 0; mv[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bin[%0d]", i), db[i], 16'(mb[i]));
            chk($sformatf("gray[%0d]", i), dg[i], 16'(mb[i] ^ (mb[i] >> 1)));
            chk($sformatf("tc[%0d]", i), 16'(dt[i]), 16'(mt[i]));
            if (mv[i]) chk($sformatf("gray_onebit[%0d]", i), 16'($countones(dg[i] ^ pg[i])), 16'd1);
            pg[i] = dg[i];
        end
    end

    initial begin
        clr = 0; load = 0; en = 1; up = 1; load_val = 0;
        repeat (2) @(negedge clk);
        chk("rst_bin", 16'(bin_a), 16'd0);
        chk("rst_gray", 16'(gray_a), 16'd0);
        chk("rst_tc", 16'(tc_a), 16'd0);
        rst_n = 1;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("seq_gray%0d", k), 16'(gray_a), 16'(exp_g[k]));
            chk($sformatf("seq_tc%0d", k), 16'(tc_a), 16'(k == 8));
        end
        en = 0; load = 1; load_val = 7;
        @(negedge clk);
        load = 0; en = 1; up = 1;
        repeat (3) begin
            @(negedge clk);
            chk("sat_bin", 16'(bin_b), 16'd7);
            chk("sat_gray", 16'(gray_b), 16'd4);
            chk("sat_tc", 16'(tc_b), 16'd1);
        end
        up = 0;
        @(negedge clk);
        chk("sat_down_bin", 16'(bin_b), 16'd6);
        chk("sat_down_tc", 16'(tc_b), 16'd0);
        load = 1; load_val = 9; en = 1; up = 1;
        @(negedge clk);
        chk("load_bin", 16'(bin_c), 16'd9);
        chk("load_gray", 16'(gray_c), 16'd13);
        chk("load_tc", 16'(tc_c), 16'd0);
        load = 0; up = 0;
        @(negedge clk);
        chk("dec_bin", 16'(bin_c), 16'd8);
        chk("dec_gray", 16'(gray_c), 16'd12);
        load = 1; load_val = 5; en = 0;
        @(negedge clk);
        chk("pre_clr_bin", 16'(bin_c), 16'd5);
        clr = 1; load = 1; en = 1; up = 1;
        @(negedge clk);
        chk("clr_bin", 16'(bin_c), 16'd0);
        chk("clr_gray", 16'(gray_c), 16'd0);
        chk("clr_tc", 16'(tc_c), 16'd0);
        clr = 0; load = 1; load_val = 6;
        @(negedge clk);
        load = 0; en = 0;
        #2 rst_n = 0;
        #1;
        chk("async_bin", 16'(bin_c), 16'd0);
        chk("async_gray", 16'(gray_c), 16'd0);
        chk("async_tc", 16'(tc_c), 16'd0);
        #1 rst_n = 1;
        en = 1; up = 1;
        @(negedge clk);
        chk("resume_bin", 16'(bin_c), 16'd1);
        chk("resume_gray", 16'(gray_c), 16'd1);
        repeat (3000) begin
            clr = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 19) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            load_val = 4'($urandom);
            @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
